block_scale_detector: RTL and testbench
=======================================

# block_scale_detector

Block-floating-point exponent detector that sits directly upstream of the float rounder. It groups valid input samples into fixed-length blocks and finds the smallest leading-zero (unsigned) or redundant-sign-bit (signed) count over each block. It delays the data by exactly one block, so each sample leaves together with the `offset` computed for its own block. The rounder then keeps OWIDTH bits without losing the block peak.

## Interface
- `IWIDTH`, 7: input/output data width.
- `OWIDTH`, 4: width of the downstream rounder output; must be < IWIDTH.
- `SIGNREP`, "UNSIGNED": "SIGNED" or "UNSIGNED" data representation.
- `BLOCKLEN`, 16: samples per block; power of two, at least 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low; the design has one clock domain.
- `clkena`  in  1  clock enable; while low, every register and the buffer hold.
- `i_valid`  in  1  input sample strobe, qualified by clkena.
- `i_data`  in  IWIDTH  input sample.
- `o_valid`  out  1  output sample strobe.
- `o_data`  out  IWIDTH  input sample delayed by BLOCKLEN accepted samples.
- `o_offset`  out  $clog2(IWIDTH-OWIDTH+1)  offset of the rounder output MSB from the input MSB for `o_data`.

## Operation
- **Accept.** A sample is accepted when `clkena & i_valid`. Every other cycle is idle: nothing changes.
- **Magnitude.**
  - UNSIGNED: `mag = i_data`, and `lz` is counted over IWIDTH bits.
  - SIGNED: `mag = i_data ^ {IWIDTH{i_data[IWIDTH-1]}}` (ones-complement, no overflow at the most negative value), and `lz` is counted over bits [IWIDTH-2:0].
- **Peak accumulation.**
  - `acc` is bitwise OR of `mag` over the block; OR is sufficient for leading-one position.
  - `cnt` runs 0..BLOCKLEN-1 per accepted sample and wraps.
  - On the last sample (`cnt == BLOCKLEN-1`), `acc|mag` goes to the lzc. `p_off <= min(lz, IWIDTH-OWIDTH)` and `acc` clears.
  - An all-zero block gives `lz` = full width, so the offset clamps to IWIDTH-OWIDTH.
- **Delay buffer.**
  - BLOCKLEN-entry RAM addressed by `cnt`, read-before-write: each accepted sample reads the entry written BLOCKLEN accepts earlier.
  - Buffer contents are not reset.
- **Primed flag.** Set when the first block completes; cleared only by reset.
- **Output.** On each accept with primed set, the following register together:
  - `o_valid <= 1` and `o_data <=` the read value.
  - If `cnt == 0`, `o_offset <= p_off`, so the offset switches exactly at the first sample of each block.
  - `o_valid` is 0 after any cycle without an accept.
- **Headroom.** The offset reserves no headroom for a rounding carry; the downstream stage saturates.

## Timing
- **Reset values:** `o_valid=0`, `o_data=0`, `o_offset=0`; `cnt`, `acc`, `p_off` and primed are 0.
- **Latency:** sample n appears on `o_data` one cycle after sample n+BLOCKLEN is accepted. There is no output before the second block starts.
- **Flow:** the block is lockstep with its input; there is no backpressure and no output with `i_valid` low.
- **Wrap-around:** `cnt` wraps BLOCKLEN-1 to 0 in the same cycle that `p_off` loads, with no bubble.
- **Reset mid-block:** the partial block is discarded; the block after reset is treated as the first, and output resumes one block later.
- **clkena low:** the last `o_valid`/`o_data`/`o_offset` values are held; `o_valid` pulses are not stretched in sample count.

## Configuration
- Macro: `BLOCK_SCALE_DETECTOR_OVERRIDE_EN`.
- **Defined:** adds ports `ovr_ena` in 1 and `ovr_offset` in offset-width.
  - While `ovr_ena` is high at a block boundary (`cnt==0` accept), `o_offset` loads `ovr_offset` instead of `p_off`.
  - Detection still runs.
- **Undefined:** the ports do not exist, and `o_offset` always comes from detection.

## Structure
- **Shared package `float_pkg`:**
  - function for offset width, `$clog2(IWIDTH-OWIDTH+1)`;
  - SIGNREP string constants;
  - the `min`/clamp helper.
- **Sub-module `float_lzc`:**
  - parameterised combinational leading-zero counter;
  - output width `$clog2(W+1)`;
  - all-zero input returns W.
- **Buffer:** inferred RAM inside the block; not a separate module.

## Test plan
All scenarios use IWIDTH=7, OWIDTH=4 and BLOCKLEN=4 unless stated.
- **Reset:** hold `rst` low with random input; expect `o_valid=0`, `o_data=0`, `o_offset=0`. Release and feed 4 samples; expect `o_valid` to stay 0.
- **Basic offsets (UNSIGNED):**
  - Block {5,5,5,5} then block {0x7F,1,2,3}.
  - Expect outputs 5,5,5,5 with `o_offset=3`, starting one cycle after the 5th accept.
  - Then 0x7F,1,2,3 with `o_offset=0`.
  - Block {0x10,…} gives offset 2.
- **Clamp:** an all-zero block gives `o_offset=3`; a block {0x08} gives lz=3, so `o_offset=3`.
- **Gaps:** toggle `i_valid` and `clkena` mid-block; expect identical data/offset sequence, `o_valid` only after accepts, and outputs held while `clkena` is low.
- **SIGNED:** block {-64,0,0,0} gives offset 0; block {-2,1,-1,0} gives offset 3; block {15,…} gives redundant count 2, so offset 2.
- **Reset and override:**
  - Assert `rst` mid-block; expect a fresh first block with no stale output.
  - With the macro defined, `ovr_ena=1` and `ovr_offset=1` give `o_offset=1` at the next boundary.

Source files
------------

// File: rtl/float_pkg.sv
// Shared helpers for the block-floating-point datapath: offset width,
// data-representation names and the clamp used by the exponent detector.
package float_pkg;

    localparam string SIGNREP_SIGNED   = "SIGNED";
    localparam string SIGNREP_UNSIGNED = "UNSIGNED";

    // Width of an offset that can range over 0..(iw-ow).
    function automatic int offset_width(input int iw, input int ow);
        return $clog2(iw - ow + 1);
    endfunction

    // Smaller of two unsigned values; clamps a leading-zero count to the
    // largest shift the rounder can absorb.
    function automatic int unsigned clamp_max(input int unsigned value,
                                              input int unsigned limit);
        return (value < limit) ? value : limit;
    endfunction

endpackage

// File: rtl/float_lzc.sv
// Combinational leading-zero counter over W bits. An all-zero input
// returns W.
module float_lzc #(
    parameter int W = 8
) (
    input  logic [W-1:0]           i_data,
    output logic [$clog2(W+1)-1:0] o_count
);

    localparam int CW = $clog2(W + 1);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_count = CW'(W - 1 - i);
            end else begin
                o_count = o_count;
            end
        end
    end

endmodule

// File: rtl/block_scale_detector.sv
// Block-floating-point exponent detector. Groups accepted samples into
// blocks of BLOCKLEN, finds the smallest leading-zero (UNSIGNED) or
// redundant-sign-bit (SIGNED) count per block, and delays the data by one
// block so each sample leaves with the offset of its own block.
// Optional feature macro: BLOCK_SCALE_DETECTOR_OVERRIDE_EN adds ovr_ena /
// ovr_offset, which replace the detected offset at a block boundary.
module block_scale_detector
    import float_pkg::*;
#(
    parameter int    IWIDTH   = 7,
    parameter int    OWIDTH   = 4,
    parameter string SIGNREP  = "UNSIGNED",
    parameter int    BLOCKLEN = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clkena,
    input  logic                                     i_valid,
    input  logic [IWIDTH-1:0]                        i_data,
`ifdef BLOCK_SCALE_DETECTOR_OVERRIDE_EN
    input  logic                                     ovr_ena,
    input  logic [offset_width(IWIDTH, OWIDTH)-1:0]  ovr_offset,
`endif
    output logic                                     o_valid,
    output logic [IWIDTH-1:0]                        o_data,
    output logic [offset_width(IWIDTH, OWIDTH)-1:0]  o_offset
);

    localparam int          OFFW      = offset_width(IWIDTH, OWIDTH);
    localparam int          CW        = $clog2(BLOCKLEN);
    localparam int          LZW       = $clog2(IWIDTH + 1);
    localparam int unsigned MAXOFF    = 32'(IWIDTH - OWIDTH);
    localparam bit          IS_SIGNED = (SIGNREP == SIGNREP_SIGNED);

    logic [CW-1:0]     r_cnt;
    logic [IWIDTH-1:0] r_acc;
    logic [OFFW-1:0]   r_p_off;
    logic              r_primed;
    logic              r_o_valid;
    logic [IWIDTH-1:0] r_o_data;
    logic [OFFW-1:0]   r_o_offset;
    logic [IWIDTH-1:0] r_buf [BLOCKLEN];

    logic              w_accept;
    logic              w_last;
    logic [IWIDTH-1:0] w_mag;
    logic [IWIDTH-1:0] w_peak;
    logic [LZW-1:0]    w_lz_full;
    logic [LZW-1:0]    w_lz;
    logic [OFFW-1:0]   w_off_next;
    logic [OFFW-1:0]   w_bound_off;

    assign w_accept = clkena & i_valid;
    assign w_last   = (r_cnt == CW'(BLOCKLEN - 1));
    assign w_peak   = r_acc | w_mag;

    // Magnitude: ones-complement for signed data so the most negative value
    // cannot overflow; its MSB is then always zero.
    always_comb begin
        if (IS_SIGNED) begin
            w_mag = i_data ^ {IWIDTH{i_data[IWIDTH-1]}};
        end else begin
            w_mag = i_data;
        end
    end

    float_lzc #(
        .W (IWIDTH)
    ) u_lzc (
        .i_data  (w_peak),
        .o_count (w_lz_full)
    );

    // For signed data the magnitude MSB is always zero, so the count over
    // bits [IWIDTH-2:0] is the full-width count minus one (all-zero gives
    // IWIDTH-1, the full width of that field).
    always_comb begin
        if (IS_SIGNED) begin
            w_lz = w_lz_full - LZW'(1);
        end else begin
            w_lz = w_lz_full;
        end
    end

    assign w_off_next = OFFW'(clamp_max({{(32 - LZW){1'b0}}, w_lz}, MAXOFF));

    // Choose the offset that is loaded at each block boundary.
    always_comb begin
`ifdef BLOCK_SCALE_DETECTOR_OVERRIDE_EN
        if (ovr_ena) begin
            w_bound_off = ovr_offset;
        end else begin
            w_bound_off = r_p_off;
        end
`else
        w_bound_off = r_p_off;
`endif
    end

    // Delay buffer write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_cnt] <= i_data;
        end
    end

    // Block counter, peak accumulator, offset detection and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= CW'(0);
            r_acc      <= IWIDTH'(0);
            r_p_off    <= OFFW'(0);
            r_primed   <= 1'b0;
            r_o_valid  <= 1'b0;
            r_o_data   <= IWIDTH'(0);
            r_o_offset <= OFFW'(0);
        end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_acc    <= IWIDTH'(0);
                r_p_off  <= w_off_next;
                r_primed <= 1'b1;
            end else begin
                r_acc <= w_peak;
            end
            if (r_primed) begin
                // Read-before-write: this entry holds the sample accepted
                // BLOCKLEN accepts ago.
                r_o_valid <= 1'b1;
                r_o_data  <= r_buf[r_cnt];
                if (r_cnt == CW'(0)) begin
                    r_o_offset <= w_bound_off;
                end
            end else begin
                r_o_valid <= 1'b0;
            end
        end else if (clkena) begin
            r_o_valid <= 1'b0;
        end
    end

    assign o_valid  = r_o_valid;
    assign o_data   = r_o_data;
    assign o_offset = r_o_offset;

endmodule

// File: tb/tb_block_scale_detector.sv
// Scoreboard bench for block_scale_detector: one UNSIGNED and one SIGNED
// instance (IWIDTH=7, OWIDTH=4, BLOCKLEN=4) share the same stimulus; the
// driver pushes hand-computed expectations per block and a negedge monitor
// pops and compares whenever an output is presented.
module tb_block_scale_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkena;
    logic       i_valid;
    logic [6:0] i_data;
    logic       ov_u, ov_s;
    logic [6:0] od_u, od_s;
    logic [1:0] oo_u, oo_s;
`ifdef BLOCK_SCALE_DETECTOR_OVERRIDE_EN
    logic       ovr_ena;
    logic [1:0] ovr_offset;
`endif

    always #5 clk = ~clk;

    block_scale_detector #(
        .IWIDTH(7), .OWIDTH(4), .SIGNREP("UNSIGNED"), .BLOCKLEN(4)
    ) u_dut_u (
        .clk(clk), .rst(rst), .clkena(clkena), .i_valid(i_valid), .i_data(i_data),
`ifdef BLOCK_SCALE_DETECTOR_OVERRIDE_EN
        .ovr_ena(ovr_ena), .ovr_offset(ovr_offset),
`endif
        .o_valid(ov_u), .o_data(od_u), .o_offset(oo_u)
    );

    block_scale_detector #(
        .IWIDTH(7), .OWIDTH(4), .SIGNREP("SIGNED"), .BLOCKLEN(4)
    ) u_dut_s (
        .clk(clk), .rst(rst), .clkena(clkena), .i_valid(i_valid), .i_data(i_data),
`ifdef BLOCK_SCALE_DETECTOR_OVERRIDE_EN
        .ovr_ena(ovr_ena), .ovr_offset(ovr_offset),
`endif
        .o_valid(ov_s), .o_data(od_s), .o_offset(oo_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] q_u[$];
    logic [8:0] q_s[$];

    // Block table: data, expected unsigned offset, expected signed offset,
    // gapped stimulus, override applied at the boundary after this block.
    localparam int NBLK = 12;
    logic [6:0] blk_d  [NBLK][4];
    logic [1:0] blk_eu [NBLK];
    logic [1:0] blk_es [NBLK];
    bit         blk_gap[NBLK];
    bit         blk_ovr[NBLK];

    bit         ce_prev  = 1'b1;
    bit         acc_prev = 1'b0;
    logic [9:0] prev_out [2];

    task automatic cmp(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut=%0d got=%h want=%h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic mon(input int k, input logic ov, input logic [6:0] od, input logic [1:0] oo);
        logic [8:0] e;
        int         sz;
        if (!ce_prev) begin
            cmp("hold", k, {6'd0, ov, od, oo}, {6'd0, prev_out[k]});
        end else if (!acc_prev) begin
            cmp("idle_valid", k, {15'd0, ov}, 16'd0);
        end else if (ov) begin
            sz = (k == 0) ? q_u.size() : q_s.size();
            if (sz == 0) begin
                cmp("unexpected_out", k, {15'd0, ov}, 16'd0);
            end else begin
                e = (k == 0) ? q_u.pop_front() : q_s.pop_front();
                cmp("data", k, {9'd0, od}, {9'd0, e[8:2]});
                cmp("offset", k, {14'd0, oo}, {14'd0, e[1:0]});
            end
        end
        prev_out[k] = {ov, od, oo};
    endtask

    // Monitor: inputs are stable at negedge, so they describe the next edge.
    always @(negedge clk) begin
        mon(0, ov_u, od_u, oo_u);
        mon(1, ov_s, od_s, oo_s);
        ce_prev  = clkena;
        acc_prev = clkena & i_valid;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_sample(input logic [6:0] d);
        i_data  = d;
        i_valid = 1'b1;
        clkena  = 1'b1;
        step();
        i_valid = 1'b0;
`ifdef BLOCK_SCALE_DETECTOR_OVERRIDE_EN
        ovr_ena = 1'b0;
`endif
    endtask

    task automatic send_block(input int b);
        logic [1:0] eu, es;
        for (int i = 0; i < 4; i++) begin
            if (blk_gap[b] && i > 0) begin
                clkena = 1'b0; i_valid = 1'b1; i_data = 7'h55; step();
                clkena = 1'b1; i_valid = 1'b0; step();
                clkena = 1'b0; i_valid = 1'b0; step();
            end
`ifdef BLOCK_SCALE_DETECTOR_OVERRIDE_EN
            if (i == 0 && b > 0) begin
                ovr_ena = blk_ovr[b-1];
            end
`endif
            send_sample(blk_d[b][i]);
        end
        eu = blk_eu[b];
        es = blk_es[b];
`ifdef BLOCK_SCALE_DETECTOR_OVERRIDE_EN
        if (blk_ovr[b]) begin
            eu = 2'd1;
            es = 2'd1;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            q_u.push_back({blk_d[b][i], eu});
            q_s.push_back({blk_d[b][i], es});
        end
    endtask

    task automatic reset_phase();
        rst = 1'b0;
        q_u.delete();
        q_s.delete();
        for (int i = 0; i < 3; i++) begin
            clkena  = 1'b1;
            i_valid = 1'b1;
            i_data  = 7'($urandom_range(0, 127));
            step();
        end
        cmp("rst_valid", 0, {15'd0, ov_u}, 16'd0);
        cmp("rst_data", 0, {9'd0, od_u}, 16'd0);
        cmp("rst_offset", 0, {14'd0, oo_u}, 16'd0);
        cmp("rst_valid", 1, {15'd0, ov_s}, 16'd0);
        cmp("rst_data", 1, {9'd0, od_s}, 16'd0);
        cmp("rst_offset", 1, {14'd0, oo_s}, 16'd0);
        i_valid = 1'b0;
        rst     = 1'b1;
        step();
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog dut=0 got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver: directed blocks, gaps, mid-block reset, optional override.
    initial begin
        blk_d[0]  = '{7'h05, 7'h05, 7'h05, 7'h05}; blk_eu[0]  = 2'd3; blk_es[0]  = 2'd3;
        blk_d[1]  = '{7'h7F, 7'h01, 7'h02, 7'h03}; blk_eu[1]  = 2'd0; blk_es[1]  = 2'd3;
        blk_d[2]  = '{7'h10, 7'h00, 7'h00, 7'h00}; blk_eu[2]  = 2'd2; blk_es[2]  = 2'd1;
        blk_d[3]  = '{7'h00, 7'h00, 7'h00, 7'h00}; blk_eu[3]  = 2'd3; blk_es[3]  = 2'd3;
        blk_d[4]  = '{7'h08, 7'h00, 7'h01, 7'h00}; blk_eu[4]  = 2'd3; blk_es[4]  = 2'd2;
        blk_d[5]  = '{7'h20, 7'h03, 7'h11, 7'h05}; blk_eu[5]  = 2'd1; blk_es[5]  = 2'd0;
        blk_d[6]  = '{7'h40, 7'h00, 7'h00, 7'h00}; blk_eu[6]  = 2'd0; blk_es[6]  = 2'd0;
        blk_d[7]  = '{7'h7E, 7'h01, 7'h7F, 7'h00}; blk_eu[7]  = 2'd0; blk_es[7]  = 2'd3;
        blk_d[8]  = '{7'h0F, 7'h0F, 7'h0F, 7'h0F}; blk_eu[8]  = 2'd3; blk_es[8]  = 2'd2;
        blk_d[9]  = '{7'h7F, 7'h7F, 7'h00, 7'h00}; blk_eu[9]  = 2'd0; blk_es[9]  = 2'd3;
        blk_d[10] = '{7'h10, 7'h10, 7'h10, 7'h10}; blk_eu[10] = 2'd2; blk_es[10] = 2'd1;
        blk_d[11] = '{7'h00, 7'h00, 7'h00, 7'h00}; blk_eu[11] = 2'd3; blk_es[11] = 2'd3;
        for (int b = 0; b < NBLK; b++) begin
            blk_gap[b] = (b == 5);
            blk_ovr[b] = (b == 10);
        end
        prev_out[0] = 10'd0;
        prev_out[1] = 10'd0;

        rst     = 1'b0;
        clkena  = 1'b1;
        i_valid = 1'b0;
        i_data  = 7'h00;
`ifdef BLOCK_SCALE_DETECTOR_OVERRIDE_EN
        ovr_ena    = 1'b0;
        ovr_offset = 2'd1;
`endif
        reset_phase();

        for (int b = 0; b <= 8; b++) begin
            send_block(b);
        end

        // Partial block, then reset mid-block: stale data must never appear.
        send_sample(7'h33);
        send_sample(7'h44);
        reset_phase();

        for (int b = 9; b < NBLK; b++) begin
            send_block(b);
        end
        clkena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end

        // Only the final block's samples remain undelivered.
        cmp("drain", 0, 16'(q_u.size()), 16'd4);
        cmp("drain", 1, 16'(q_s.size()), 16'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
